// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch stage over a byte-wide memory port. Each 32-bit
// instruction is read as four bytes. Byte k comes from pc+k (modulo 2^32) and
// is placed little-endian into the word. The finished word is held for the
// IF/ID stage until it is accepted. stallreq_o freezes the PC register until
// the word is taken, so the PC advances once per delivered instruction.
//
// Ports
//   clk, rst       : clock; synchronous active-high reset
//   rdy            : global ready; 0 freezes every register in the block
//   pc_i           : current PC, latched at the start of each fetch
//   branch_flag_i  : flush / redirect from ID; abandons any fetch in flight
//   stall_i        : IF/ID stalled; the delivered word is held while high
//   mem_ack_i      : single-cycle byte-ready strobe from the memory controller
//   mem_data_i     : read byte, valid with mem_ack_i
//   mem_req_o      : registered byte read request
//   mem_addr_o     : registered byte address, stable while mem_req_o=1
//   if_valid_o     : if_pc_o / if_inst_o hold a complete instruction
//   if_pc_o        : address of the delivered instruction
//   if_inst_o      : assembled instruction word
//   stallreq_o     : combinational; 1 holds the PC register
// -----------------------------------------------------------------------------
module inst_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] pc_i,
    input  logic        branch_flag_i,
    input  logic        stall_i,
    input  logic        mem_ack_i,
    input  logic [7:0]  mem_data_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q,    state_d;
    logic [1:0]  cnt_q,      cnt_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        mem_req_q,  mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q,    if_pc_d;
    logic [31:0] if_inst_q,  if_inst_d;

    // Next-state and registered-output logic.
    always_comb begin
        // NOTE: every signal gets its hold value before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        cnt_d      = cnt_q;
        fetch_pc_d = fetch_pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;

        // With rdy low the defaults above hold everything, so ack and flush
        // are ignored without extra qualification.
        if (rdy) begin
            if (branch_flag_i) begin
                // Flush wins over ack and accept; any partial bytes are simply
                // never marked valid.
                state_d    = IDLE;
                cnt_d      = 2'd0;
                mem_req_d  = 1'b0;
                if_valid_d = 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        fetch_pc_d = pc_i;
                        cnt_d      = 2'd0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_i;
                        if_valid_d = 1'b0;
                        state_d    = FETCH;
                    end
                    FETCH: begin
                        if (mem_ack_i) begin
                            // Byte cnt lands in bits [8*cnt+7 : 8*cnt].
                            if_inst_d[{cnt_q, 3'b000} +: 8] = mem_data_i;
                            if (cnt_q != 2'd3) begin
                                cnt_d      = cnt_q + 2'd1;
                                // Plain 32-bit add, so a fetch near the top of
                                // memory wraps to address 0.
                                mem_addr_d = fetch_pc_q + {30'd0, cnt_q} + 32'd1;
                            end else begin
                                mem_req_d  = 1'b0;
                                if_valid_d = 1'b1;
                                if_pc_d    = fetch_pc_q;
                                state_d    = DONE;
                            end
                        end
                    end
                    DONE: begin
                        // stall_i low means the word is taken this cycle.
                        if (!stall_i) begin
                            if_valid_d = 1'b0;
                            state_d    = IDLE;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples its _d value from before the edge. Reset is synchronous and
    // overrides rdy and branch_flag_i.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            fetch_pc_q <= 32'd0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'd0;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'd0;
            if_inst_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
        end
    end

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;
    assign if_valid_o = if_valid_q;
    assign if_pc_o    = if_pc_q;
    assign if_inst_o  = if_inst_q;

    // The PC is held until the finished word is accepted. It may advance only
    // in DONE when IF/ID is not stalled, which gives one advance per
    // instruction.
    assign stallreq_o = !rst && ((state_q != DONE) || stall_i);

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//
// Directed bench for inst_fetch. It drives a small byte memory model and checks
// registered outputs 1 time unit after each rising edge. Expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [31:0] pc_i;
    logic        branch_flag_i;
    logic        stall_i;
    logic        mem_ack_i;
    logic [7:0]  mem_data_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        stallreq_o;

    int total = 0;
    int bad   = 0;
    int pc_adv = 0;
    int adv_base;

    inst_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .pc_i          (pc_i),
        .branch_flag_i (branch_flag_i),
        .stall_i       (stall_i),
        .mem_ack_i     (mem_ack_i),
        .mem_data_i    (mem_data_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_inst_o     (if_inst_o),
        .stallreq_o    (stallreq_o)
    );

    always #5 clk = ~clk;

    // Byte memory. 0x10..0x13 holds the word 0x00100513. Every other byte is
    // addr[7:0] ^ 0xA5.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h10:  return 8'h13;
            32'h11:  return 8'h05;
            32'h12:  return 8'h10;
            32'h13:  return 8'h00;
            default: return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    always_comb mem_data_i = mem_byte(mem_addr_o);

    // Count the cycles in which the PC register is allowed to advance.
    always @(posedge clk) begin
        if (!rst && rdy && !stallreq_o) pc_adv++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; pc_i = 32'h10; branch_flag_i = 1'b0;
        stall_i = 1'b0; mem_ack_i = 1'b0;
        tick(); tick();

        // ---- reset state ----
        chk("rst_req",      {31'd0, mem_req_o},  32'd0);
        chk("rst_addr",     mem_addr_o,          32'd0);
        chk("rst_valid",    {31'd0, if_valid_o}, 32'd0);
        chk("rst_pc",       if_pc_o,             32'd0);
        chk("rst_inst",     if_inst_o,           32'd0);
        chk("rst_stallreq", {31'd0, stallreq_o}, 32'd0);

        // ---- basic fetch, zero wait ----
        rst = 1'b0; mem_ack_i = 1'b1;                   // cycle t: IDLE
        #1 chk("idle_stallreq", {31'd0, stallreq_o}, 32'd1);
        tick();                                         // t+1
        chk("b_req",   {31'd0, mem_req_o}, 32'd1);
        chk("b_addr0", mem_addr_o, 32'h10);
        tick(); chk("b_addr1", mem_addr_o, 32'h11);     // t+2
        tick(); chk("b_addr2", mem_addr_o, 32'h12);     // t+3
        tick(); chk("b_addr3", mem_addr_o, 32'h13);     // t+4
        chk("b_valid_early", {31'd0, if_valid_o}, 32'd0);
        tick();                                         // t+5
        mem_ack_i = 1'b0;
        chk("b_valid",    {31'd0, if_valid_o}, 32'd1);
        chk("b_inst",     if_inst_o, 32'h00100513);
        chk("b_pc",       if_pc_o, 32'h10);
        chk("b_req_drop", {31'd0, mem_req_o}, 32'd0);
        #1 chk("b_stallreq", {31'd0, stallreq_o}, 32'd0);
        tick();
        chk("b_valid_fall", {31'd0, if_valid_o}, 32'd0);

        // ---- wait states: each ack comes 3 cycles late ----
        pc_i = 32'h10;                                  // IDLE now
        tick();                                         // FETCH, addr 0x10
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 3; w++) begin
                chk($sformatf("ws_hold%0d_%0d", k, w), mem_addr_o, 32'h10 + k);
                tick();
            end
            mem_ack_i = 1'b1;
            chk($sformatf("ws_ack%0d", k), mem_addr_o, 32'h10 + k);
            tick();
            mem_ack_i = 1'b0;
        end
        chk("ws_valid", {31'd0, if_valid_o}, 32'd1);
        chk("ws_inst",  if_inst_o, 32'h00100513);

        // ---- downstream stall for 4 cycles ----
        stall_i = 1'b1;
        adv_base = pc_adv;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("st_stallreq%0d", c), {31'd0, stallreq_o}, 32'd1);
            chk($sformatf("st_valid%0d", c),    {31'd0, if_valid_o}, 32'd1);
            chk($sformatf("st_inst%0d", c),     if_inst_o, 32'h00100513);
            chk($sformatf("st_pc%0d", c),       if_pc_o, 32'h10);
            tick();
        end
        stall_i = 1'b0;
        #1 chk("st_release_stallreq", {31'd0, stallreq_o}, 32'd0);
        pc_i = 32'h40;
        tick();
        chk("st_valid_fall", {31'd0, if_valid_o}, 32'd0);
        chk("st_one_advance", pc_adv - adv_base, 32'd1);

        // ---- flush mid-fetch with ack in the same cycle, cnt=2 ----
        mem_ack_i = 1'b1;                               // IDLE latches 0x40
        tick(); chk("fl_addr0", mem_addr_o, 32'h40);
        tick(); chk("fl_addr1", mem_addr_o, 32'h41);
        tick(); chk("fl_addr2", mem_addr_o, 32'h42);    // cnt=2
        branch_flag_i = 1'b1;
        tick();
        branch_flag_i = 1'b0; pc_i = 32'h80;
        chk("fl_req_drop", {31'd0, mem_req_o},  32'd0);
        chk("fl_no_valid", {31'd0, if_valid_o}, 32'd0);
        tick();
        chk("fl_new_req",  {31'd0, mem_req_o}, 32'd1);
        chk("fl_new_addr", mem_addr_o, 32'h80);
        tick(); tick(); tick(); tick();
        chk("fl_valid", {31'd0, if_valid_o}, 32'd1);
        chk("fl_pc",    if_pc_o, 32'h80);
        chk("fl_inst",  if_inst_o, 32'h26272425);
        tick();                                         // accepted, IDLE

        // ---- rdy gating mid-fetch ----
        pc_i = 32'h20;
        tick(); chk("rd_addr0", mem_addr_o, 32'h20);
        tick(); chk("rd_addr1", mem_addr_o, 32'h21);
        rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            branch_flag_i = (c == 1);
            tick();
            chk($sformatf("rd_hold_addr%0d", c), mem_addr_o, 32'h21);
            chk($sformatf("rd_hold_req%0d", c),  {31'd0, mem_req_o}, 32'd1);
        end
        branch_flag_i = 1'b0; rdy = 1'b1;
        tick(); chk("rd_addr2", mem_addr_o, 32'h22);
        tick(); chk("rd_addr3", mem_addr_o, 32'h23);
        tick();
        chk("rd_valid", {31'd0, if_valid_o}, 32'd1);
        chk("rd_inst",  if_inst_o, 32'h86878485);
        tick();

        // ---- misaligned fetch wrapping past 0xFFFFFFFF ----
        pc_i = 32'hFFFF_FFFE;
        tick(); chk("wr_addr0", mem_addr_o, 32'hFFFF_FFFE);
        tick(); chk("wr_addr1", mem_addr_o, 32'hFFFF_FFFF);
        tick(); chk("wr_addr2", mem_addr_o, 32'h0000_0000);
        tick(); chk("wr_addr3", mem_addr_o, 32'h0000_0001);
        tick();
        chk("wr_valid", {31'd0, if_valid_o}, 32'd1);
        chk("wr_pc",    if_pc_o, 32'hFFFF_FFFE);
        chk("wr_inst",  if_inst_o, 32'hA4A55A5B);
        tick();

        // ---- reset mid-fetch with an ack in the reset cycle ----
        pc_i = 32'h10;
        tick(); tick();
        chk("rm_addr1", mem_addr_o, 32'h11);
        rst = 1'b1;
        #1 chk("rm_stallreq", {31'd0, stallreq_o}, 32'd0);
        tick();
        rst = 1'b0; mem_ack_i = 1'b0;
        chk("rm_req",   {31'd0, mem_req_o},  32'd0);
        chk("rm_addr",  mem_addr_o,          32'd0);
        chk("rm_valid", {31'd0, if_valid_o}, 32'd0);
        chk("rm_pc",    if_pc_o,             32'd0);
        chk("rm_inst",  if_inst_o,           32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
